axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_arbiter
// Purpose  : Round-robin AW arbiter merging NumSlv AXI write requesters onto one
//            downstream port; W and B are steered in AW-grant order.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter #(
    parameter int unsigned NumSlv   = 4,
    parameter int unsigned MaxTrans = 8,
    parameter type aw_chan_t = logic,
    parameter type w_chan_t  = struct packed { logic last; },
    parameter type b_chan_t  = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumSlv-1:0]     slv_aw_valid_i,
    output logic [NumSlv-1:0]     slv_aw_ready_o,
    input  aw_chan_t [NumSlv-1:0] slv_aw_i,
    input  logic [NumSlv-1:0]     slv_w_valid_i,
    output logic [NumSlv-1:0]     slv_w_ready_o,
    input  w_chan_t [NumSlv-1:0]  slv_w_i,
    output logic [NumSlv-1:0]     slv_b_valid_o,
    input  logic [NumSlv-1:0]     slv_b_ready_i,
    output b_chan_t [NumSlv-1:0]  slv_b_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output aw_chan_t              mst_aw_o,
    output logic                  mst_w_valid_o,
    input  logic                  mst_w_ready_i,
    output w_chan_t               mst_w_o,
    input  logic                  mst_b_valid_i,
    output logic                  mst_b_ready_o,
    input  b_chan_t               mst_b_i
);

    localparam int unsigned c_idx_w = (NumSlv > 1) ? $clog2(NumSlv) : 1;
    localparam int unsigned c_ptr_w = $clog2(MaxTrans);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(MaxTrans);

    logic [c_idx_w-1:0] r_ptr;
    logic               r_lock;
    logic [c_idx_w-1:0] r_lock_idx;

    logic [c_idx_w-1:0] w_cand;
    logic [c_idx_w-1:0] w_rr_idx;
    logic               w_rr_found;
    logic [c_idx_w-1:0] w_sel;
    logic               w_full;
    logic               w_aw_hs;

    logic [c_idx_w-1:0] r_wq_mem [MaxTrans];
    logic [c_ptr_w-1:0] r_wq_rptr;
    logic [c_ptr_w-1:0] r_wq_wptr;
    logic [c_cnt_w-1:0] r_wq_cnt;
    logic [c_idx_w-1:0] w_wq_head;
    logic               w_wq_nempty;
    logic               w_wq_pop;

    logic [c_idx_w-1:0] r_bq_mem [MaxTrans];
    logic [c_ptr_w-1:0] r_bq_rptr;
    logic [c_ptr_w-1:0] r_bq_wptr;
    logic [c_cnt_w-1:0] r_bq_cnt;
    logic [c_idx_w-1:0] w_bq_head;
    logic               w_bq_nempty;
    logic               w_bq_pop;

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        w_cand     = r_ptr;
        w_rr_idx   = r_ptr;
        w_rr_found = 1'b0;
        for (int unsigned i = 0; i < NumSlv; i++) begin
            w_cand = c_idx_w'((32'(r_ptr) + i) % NumSlv);
            if (!w_rr_found && slv_aw_valid_i[w_cand]) begin
                w_rr_idx   = w_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_sel  = r_lock ? r_lock_idx : w_rr_idx;
    assign w_full = (r_wq_cnt == c_full) || (r_bq_cnt == c_full);

    assign mst_aw_valid_o = !w_full && (r_lock ? slv_aw_valid_i[r_lock_idx] : w_rr_found);
    assign mst_aw_o       = slv_aw_i[w_sel];
    assign w_aw_hs        = mst_aw_valid_o && mst_aw_ready_i;

    always_comb begin
        slv_aw_ready_o = '0;
        if (!w_full) begin
            slv_aw_ready_o[w_sel] = mst_aw_ready_i;
        end
    end

    // A stalled request keeps its grant until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_lock     <= mst_aw_valid_o && !mst_aw_ready_i;
            r_lock_idx <= w_sel;
            if (w_aw_hs) begin
                r_ptr <= c_idx_w'((32'(w_sel) + 32'd1) % NumSlv);
            end
        end
    end

    // Order FIFO storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (w_aw_hs) begin
            r_wq_mem[r_wq_wptr] <= w_sel;
            r_bq_mem[r_bq_wptr] <= w_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wq_rptr <= '0;
            r_wq_wptr <= '0;
            r_wq_cnt  <= '0;
            r_bq_rptr <= '0;
            r_bq_wptr <= '0;
            r_bq_cnt  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_wq_wptr <= r_wq_wptr + 1'b1;
                r_bq_wptr <= r_bq_wptr + 1'b1;
            end
            if (w_wq_pop) begin
                r_wq_rptr <= r_wq_rptr + 1'b1;
            end
            if (w_bq_pop) begin
                r_bq_rptr <= r_bq_rptr + 1'b1;
            end
            r_wq_cnt <= r_wq_cnt + c_cnt_w'(w_aw_hs) - c_cnt_w'(w_wq_pop);
            r_bq_cnt <= r_bq_cnt + c_cnt_w'(w_aw_hs) - c_cnt_w'(w_bq_pop);
        end
    end

    assign w_wq_head   = r_wq_mem[r_wq_rptr];
    assign w_wq_nempty = (r_wq_cnt != '0);
    assign mst_w_o       = slv_w_i[w_wq_head];
    assign mst_w_valid_o = w_wq_nempty && slv_w_valid_i[w_wq_head];
    assign w_wq_pop      = mst_w_valid_o && mst_w_ready_i && mst_w_o.last;

    always_comb begin
        slv_w_ready_o = '0;
        if (w_wq_nempty) begin
            slv_w_ready_o[w_wq_head] = mst_w_ready_i;
        end
    end

    assign w_bq_head     = r_bq_mem[r_bq_rptr];
    assign w_bq_nempty   = (r_bq_cnt != '0);
    assign mst_b_ready_o = w_bq_nempty && slv_b_ready_i[w_bq_head];
    assign w_bq_pop      = mst_b_valid_i && mst_b_ready_o;

    always_comb begin
        slv_b_valid_o = '0;
        for (int unsigned i = 0; i < NumSlv; i++) begin
            slv_b_o[i] = mst_b_i;
        end
        if (w_bq_nempty) begin
            slv_b_valid_o[w_bq_head] = mst_b_valid_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_arbiter
// Purpose  : Directed self-checking bench for axi_wr_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_arbiter;

    typedef logic [7:0] aw_t;
    typedef struct packed { logic [7:0] data; logic last; } w_t;
    typedef logic [1:0] b_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    slv_aw_valid, slv_aw_ready;
    aw_t  [3:0]    slv_aw;
    logic [3:0]    slv_w_valid, slv_w_ready;
    w_t   [3:0]    slv_w;
    logic [3:0]    slv_b_valid, slv_b_ready;
    b_t   [3:0]    slv_b;
    logic          mst_aw_valid, mst_aw_ready;
    aw_t           mst_aw;
    logic          mst_w_valid, mst_w_ready;
    w_t            mst_w;
    logic          mst_b_valid, mst_b_ready;
    b_t            mst_b;

    int n_checks = 0;
    int n_errors = 0;

    axi_wr_arbiter #(
        .NumSlv    (4),
        .MaxTrans  (8),
        .aw_chan_t (aw_t),
        .w_chan_t  (w_t),
        .b_chan_t  (b_t)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slv_aw_valid_i (slv_aw_valid),
        .slv_aw_ready_o (slv_aw_ready),
        .slv_aw_i       (slv_aw),
        .slv_w_valid_i  (slv_w_valid),
        .slv_w_ready_o  (slv_w_ready),
        .slv_w_i        (slv_w),
        .slv_b_valid_o  (slv_b_valid),
        .slv_b_ready_i  (slv_b_ready),
        .slv_b_o        (slv_b),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .mst_aw_o       (mst_aw),
        .mst_w_valid_o  (mst_w_valid),
        .mst_w_ready_i  (mst_w_ready),
        .mst_w_o        (mst_w),
        .mst_b_valid_i  (mst_b_valid),
        .mst_b_ready_o  (mst_b_ready),
        .mst_b_i        (mst_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = 99;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                r = i;
                n++;
            end
        end
        return (n == 1) ? r : 99;
    endfunction

    task automatic idle_inputs();
        slv_aw_valid = '0;
        slv_w_valid  = '0;
        slv_b_ready  = '0;
        mst_aw_ready = 1'b0;
        mst_w_ready  = 1'b0;
        mst_b_valid  = 1'b0;
        mst_b        = '0;
        for (int i = 0; i < 4; i++) begin
            slv_aw[i] = aw_t'(8'hA0 + i);
            slv_w[i]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with downstream/upstream handshakes tempting the outputs
        idle_inputs();
        mst_b_valid = 1'b1;
        slv_b_ready = 4'hF;
        slv_w_valid = 4'hF;
        mst_w_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_aw_valid", 32'(mst_aw_valid), 0);
        chk("rst_w_valid", 32'(mst_w_valid), 0);
        chk("rst_b_ready", 32'(mst_b_ready), 0);
        chk("rst_w_ready", 32'(slv_w_ready), 0);
        chk("rst_b_valid", 32'(slv_b_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_w_valid", 32'(mst_w_valid), 0);
        chk("post_rst_b_valid", 32'(slv_b_valid), 0);

        // Round-robin with all requesters valid
        do_reset();
        slv_aw_valid = 4'hF;
        mst_aw_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", oh_idx(slv_aw_ready), k % 4);
            chk("rr_payload", 32'(mst_aw), 32'h A0 + (k % 4));
            @(negedge clk);
        end

        // Grant lock under backpressure, then pointer lands on 3
        do_reset();
        slv_aw_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) slv_aw_valid = 4'b0101;
            #1;
            chk("lock_valid", 32'(mst_aw_valid), 1);
            chk("lock_payload", 32'(mst_aw), 32'hA2);
            @(negedge clk);
        end
        mst_aw_ready = 1'b1;
        #1;
        chk("lock_hs_ready", 32'(slv_aw_ready), 32'b0100);
        @(negedge clk);
        slv_aw_valid = 4'hF;
        #1;
        chk("ptr_after_lock", oh_idx(slv_aw_ready), 3);
        @(negedge clk);

        // W ordering: AW 1 then 3, then two 4-beat bursts
        do_reset();
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        slv_aw_valid = 4'b0010;
        slv_w_valid  = 4'b1010;
        slv_w[1] = '{data: 8'h10, last: 1'b1};
        slv_w[3] = '{data: 8'h30, last: 1'b1};
        #1;
        chk("w_no_bypass", 32'(mst_w_valid), 0);
        chk("w_ready_empty", 32'(slv_w_ready), 0);
        @(negedge clk);
        slv_aw_valid = 4'b1000;
        slv_w_valid  = 4'b0000;
        #1;
        chk("aw_second", oh_idx(slv_aw_ready), 3);
        @(negedge clk);
        slv_aw_valid = 4'b0000;
        slv_w_valid  = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            slv_w[1] = '{data: 8'(8'h10 + k), last: (k == 3)};
            slv_w[3] = '{data: 8'h30, last: 1'b1};
            #1;
            chk("w1_ready", 32'(slv_w_ready), 32'b0010);
            chk("w1_data", 32'(mst_w.data), 32'h10 + k);
            chk("w1_last", 32'(mst_w.last), (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            slv_w[3] = '{data: 8'(8'h30 + k), last: (k == 3)};
            #1;
            chk("w3_ready", 32'(slv_w_ready), 32'b1000);
            chk("w3_data", 32'(mst_w.data), 32'h30 + k);
            @(negedge clk);
        end
        #1;
        chk("w_drained", 32'(mst_w_valid), 0);

        // FIFO full: 8 AWs, 9th stalls until both a W last and a B pop
        do_reset();
        slv_aw_valid = 4'b0001;
        mst_aw_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("full_aw_valid", 32'(mst_aw_valid), 0);
        chk("full_aw_ready", 32'(slv_aw_ready), 0);
        slv_w_valid = 4'b0001;
        slv_w[0]    = '{data: 8'h55, last: 1'b1};
        mst_w_ready = 1'b1;
        #1;
        chk("full_w_valid", 32'(mst_w_valid), 1);
        chk("full_wpop_aw_ready", 32'(slv_aw_ready), 0);
        @(negedge clk);
        slv_w_valid = 4'b0000;
        #1;
        chk("full_b_still", 32'(slv_aw_ready), 0);
        mst_b_valid = 1'b1;
        slv_b_ready = 4'b0001;
        #1;
        chk("full_b_route", 32'(slv_b_valid), 32'b0001);
        chk("full_bpop_aw_ready", 32'(slv_aw_ready), 0);
        @(negedge clk);
        mst_b_valid = 1'b0;
        #1;
        chk("free_aw_ready", 32'(slv_aw_ready), 32'b0001);
        chk("free_aw_valid", 32'(mst_aw_valid), 1);

        // B ordering: AW from 2 then 0
        do_reset();
        mst_aw_ready = 1'b1;
        slv_aw_valid = 4'b0100;
        #1;
        chk("b_aw_first", oh_idx(slv_aw_ready), 2);
        @(negedge clk);
        slv_aw_valid = 4'b0001;
        #1;
        chk("b_aw_second", oh_idx(slv_aw_ready), 0);
        @(negedge clk);
        slv_aw_valid = 4'b0000;
        mst_b_valid  = 1'b1;
        mst_b        = 2'b01;
        slv_b_ready  = 4'b0001;
        #1;
        chk("b1_valid", 32'(slv_b_valid), 32'b0100);
        chk("b1_ready_nonhead", 32'(mst_b_ready), 0);
        chk("b_bcast", 32'(slv_b[0]), 32'b01);
        slv_b_ready = 4'b0101;
        #1;
        chk("b1_ready", 32'(mst_b_ready), 1);
        @(negedge clk);
        mst_b       = 2'b10;
        slv_b_ready = 4'b0100;
        #1;
        chk("b2_valid", 32'(slv_b_valid), 32'b0001);
        chk("b2_ready_nonhead", 32'(mst_b_ready), 0);
        slv_b_ready = 4'b0001;
        #1;
        chk("b2_ready", 32'(mst_b_ready), 1);
        chk("b2_data", 32'(slv_b[0]), 32'b10);
        @(negedge clk);
        #1;
        chk("b_empty_valid", 32'(slv_b_valid), 0);
        chk("b_empty_ready", 32'(mst_b_ready), 0);

        // Reset mid-burst with 3 outstanding
        do_reset();
        mst_aw_ready = 1'b1;
        slv_aw_valid = 4'b0111;
        repeat (3) @(negedge clk);
        slv_aw_valid = 4'b0000;
        slv_w_valid  = 4'b0001;
        slv_w[0]     = '{data: 8'h77, last: 1'b0};
        mst_w_ready  = 1'b1;
        #1;
        chk("pre_rst_w_valid", 32'(mst_w_valid), 1);
        @(negedge clk);
        rst_n       = 1'b0;
        slv_w_valid = 4'hF;
        mst_b_valid = 1'b1;
        slv_b_ready = 4'hF;
        #1;
        chk("mid_rst_w_valid", 32'(mst_w_valid), 0);
        chk("mid_rst_w_ready", 32'(slv_w_ready), 0);
        chk("mid_rst_b_valid", 32'(slv_b_valid), 0);
        chk("mid_rst_b_ready", 32'(mst_b_ready), 0);
        chk("mid_rst_aw_valid", 32'(mst_aw_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_w_valid", 32'(mst_w_valid), 0);
        chk("after_rst_b_valid", 32'(slv_b_valid), 0);
        slv_w_valid  = 4'h0;
        mst_b_valid  = 1'b0;
        slv_aw_valid = 4'b1010;
        #1;
        chk("after_rst_grant", oh_idx(slv_aw_ready), 1);
        @(negedge clk);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
